hall_pos_tracker: RTL and testbench
===================================

HALL_POS_TRACKER -- requirements
Module: hall_pos_tracker

Interface
REQ-001 SHALL have parameter POS_W, default 32, position counter width (two's complement).
REQ-002 SHALL have parameter FILT_LEN, default 4, consecutive stable cycles required to accept a hall code (range 1..255).
REQ-003 SHALL have parameter PER_W, default 24, edge-period counter width.
REQ-004 SHALL have parameter DIR_INV, default 0, 1 = swap forward/reverse counting sense.
REQ-005 SHALL use one clock with synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 hall  in  3  raw asynchronous sensors {a,b,c}.
REQ-008 pos_clr  in  1  synchronous position clear.
REQ-009 err_clr  in  1  clears sticky hall_err.
REQ-010 position  out  POS_W  signed accumulated commutation steps.
REQ-011 dir  out  1  direction of last accepted step, 1 = forward.
REQ-012 step_valid  out  1  one-cycle pulse per accepted step.
REQ-013 hall_err  out  1  sticky invalid-code/illegal-jump flag.
REQ-014 period  out  PER_W  clk cycles between the last two accepted steps.
REQ-015 period_valid  out  1  one-cycle pulse when period updates.
REQ-016 stall  out  1  period counter saturated (motor stopped).

Function
REQ-017 SHALL pass hall through a 2-flop synchroniser, then a filter loading the filtered code only after FILT_LEN consecutive identical synchronised samples.
REQ-018 SHALL update position/step_valid exactly FILT_LEN+3 clk edges after a stable hall change.
REQ-019 Forward sequence SHALL be 001->011->010->110->100->101->001; a forward transition adds +1, reverse adds -1 (signs swapped when DIR_INV=1).
REQ-020 Identical consecutive filtered codes SHALL produce no step.
REQ-021 Codes 000 and 111 SHALL set hall_err, cause no step, and leave the stored previous code unchanged.
REQ-022 A valid-to-valid jump of two or three sequence positions SHALL set hall_err, cause no step, and update the stored previous code.
REQ-023 First valid filtered code after reset SHALL be stored as previous code with no step.
REQ-024 position SHALL wrap modulo 2^POS_W (0x7FFF...F +1 -> 0x800...0).
REQ-025 pos_clr SHALL force position to 0 on the next edge; on coincidence with a step, clear wins but step_valid and dir still update.
REQ-026 err_clr coincident with a new error SHALL leave hall_err = 1 (set wins).
REQ-027 Period counter SHALL increment every cycle, saturate at 2^PER_W-1 and assert stall while saturated.
REQ-028 On each accepted step the counter value SHALL load period, pulse period_valid, restart the counter at 1, and deassert stall; no period_valid on the first step after reset or after stall.

Reset
REQ-029 Reset SHALL zero position, period, filter and synchroniser state, stored code valid flag; dir=1, step_valid=0, period_valid=0, hall_err=0, stall=0.
REQ-030 Reset asserted mid-filter or mid-period SHALL discard partial state; recovery follows REQ-023.

Configuration
REQ-031 Macro HALL_PERIOD_EN SHALL compile in the period counter, period, period_valid and stall logic.
REQ-032 Without HALL_PERIOD_EN, period SHALL be tied 0, period_valid and stall tied 0, and no counter flops SHALL exist.

Structure
REQ-033 Package servo_hall_pkg SHALL hold the hall code constants, invalid-code constants and a next/prev-code lookup function.
REQ-034 Synchroniser plus stability filter SHALL be sub-module hall_filter (parameter FILT_LEN, 3-bit in/out, valid flag).

Verification
REQ-035 Reset, hall 001 held, then six forward steps each held 20 cycles -> position 6, six step_valid pulses, five period_valid pulses with period 20.
REQ-036 Reverse sequence 001->101->100 -> position -2, dir=0; DIR_INV=1 build -> position +2.
REQ-037 hall 011 glitched to 010 for FILT_LEN-1 cycles -> no step, no error; held FILT_LEN cycles -> one step.
REQ-038 hall 000 then jump 001->110 -> hall_err=1, position unchanged; err_clr with coincident 111 -> hall_err stays 1.
REQ-039 POS_W=8, position 127 plus one forward step -> -128; pos_clr on same cycle as step -> 0.
REQ-040 PER_W=4, no edges for 20 cycles -> stall=1 at count 15; next step -> stall=0, no period_valid.

Source files
------------

// File: rtl/servo_hall_pkg.sv
// Hall-sensor code constants and the commutation-sequence lookup shared by the
// filter and position tracker.
package servo_hall_pkg;

    // Forward commutation order: S0 -> S1 -> ... -> S5 -> S0
    localparam logic [2:0] HALL_S0   = 3'b001;
    localparam logic [2:0] HALL_S1   = 3'b011;
    localparam logic [2:0] HALL_S2   = 3'b010;
    localparam logic [2:0] HALL_S3   = 3'b110;
    localparam logic [2:0] HALL_S4   = 3'b100;
    localparam logic [2:0] HALL_S5   = 3'b101;
    localparam logic [2:0] HALL_BAD0 = 3'b000;
    localparam logic [2:0] HALL_BAD7 = 3'b111;

    function automatic logic hall_is_valid(input logic [2:0] code);
        hall_is_valid = (code != HALL_BAD0) && (code != HALL_BAD7);
    endfunction

    // Neighbour of a valid code one position forward (fwd=1) or back (fwd=0).
    function automatic logic [2:0] hall_adj(input logic [2:0] code, input logic fwd);
        logic [2:0] r;
        case (code)
            HALL_S0: r = fwd ? HALL_S1 : HALL_S5;
            HALL_S1: r = fwd ? HALL_S2 : HALL_S0;
            HALL_S2: r = fwd ? HALL_S3 : HALL_S1;
            HALL_S3: r = fwd ? HALL_S4 : HALL_S2;
            HALL_S4: r = fwd ? HALL_S5 : HALL_S3;
            HALL_S5: r = fwd ? HALL_S0 : HALL_S4;
            default: r = HALL_BAD0;
        endcase
        hall_adj = r;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchroniser plus stability filter for the 3-bit hall code.
// o_valid pulses for one cycle each time a newly stable code is loaded into o_code.
module hall_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [2:0] i_hall,
    output logic [2:0] o_code,
    output logic       o_valid
);

    localparam logic [7:0] LEN = 8'(FILT_LEN);

    logic [2:0] r_sync1, r_sync2, r_cand, r_code;
    logic [1:0] r_fill;
    logic [7:0] r_cnt;
    logic       r_new;

    logic       w_same, w_sat;
    logic [7:0] w_cnt_nxt;

    assign w_same    = (r_sync2 == r_cand) && (r_cnt != 8'd0);
    assign w_sat     = w_same && (r_cnt == LEN);
    assign w_cnt_nxt = !w_same ? 8'd1 : (w_sat ? LEN : r_cnt + 8'd1);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fill  <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_new   <= 1'b0;
        end else begin
            r_sync1 <= i_hall;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            r_new   <= 1'b0;
            // Ignore the reset contents of the synchroniser so a short filter
            // never accepts a phantom 000 right after reset.
            if (r_fill[1]) begin
                r_cand <= r_sync2;
                r_cnt  <= w_cnt_nxt;
                if ((w_cnt_nxt == LEN) && !w_sat) begin
                    r_code <= r_sync2;
                    r_new  <= 1'b1;
                end
            end
        end
    end

    assign o_code  = r_code;
    assign o_valid = r_new;

endmodule

// File: rtl/hall_pos_tracker.sv
// Hall-sensor commutation tracker: filtered code -> signed position, direction, error.
// Define HALL_PERIOD_EN to build the edge-period counter, period_valid and stall outputs.
module hall_pos_tracker
    import servo_hall_pkg::*;
#(
    parameter int POS_W    = 32,
    parameter int FILT_LEN = 4,
    parameter int PER_W    = 24,
    parameter int DIR_INV  = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [2:0]              i_hall,
    input  logic                    i_pos_clr,
    input  logic                    i_err_clr,
    output logic signed [POS_W-1:0] o_position,
    output logic                    o_dir,
    output logic                    o_step_valid,
    output logic                    o_hall_err,
    output logic [PER_W-1:0]        o_period,
    output logic                    o_period_valid,
    output logic                    o_stall
);

    localparam bit               INV = (DIR_INV != 0);
    localparam logic [POS_W-1:0] ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic [2:0]       w_code;
    logic             w_new;
    logic             w_step, w_fwd, w_err, w_store, w_up;

    logic [POS_W-1:0] r_pos;
    logic             r_dir, r_step, r_err, r_prev_vld;
    logic [2:0]       r_prev;

    hall_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_hall    (i_hall),
        .o_code    (w_code),
        .o_valid   (w_new)
    );

    always_comb begin
        w_step  = 1'b0;
        w_fwd   = 1'b0;
        w_err   = 1'b0;
        w_store = 1'b0;
        if (w_new) begin
            if (!hall_is_valid(w_code)) begin
                w_err = 1'b1;
            end else if (!r_prev_vld) begin
                w_store = 1'b1;
            end else if (w_code != r_prev) begin
                w_store = 1'b1;
                if (w_code == hall_adj(r_prev, 1'b1)) begin
                    w_step = 1'b1;
                    w_fwd  = 1'b1;
                end else if (w_code == hall_adj(r_prev, 1'b0)) begin
                    w_step = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
        end
    end

    assign w_up = w_fwd ^ INV;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pos      <= '0;
            r_dir      <= 1'b1;
            r_step     <= 1'b0;
            r_err      <= 1'b0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_step <= w_step;
            if (w_step)
                r_dir <= w_up;
            if (i_pos_clr)
                r_pos <= '0;
            else if (w_step)
                r_pos <= w_up ? r_pos + ONE : r_pos - ONE;
            if (w_err)
                r_err <= 1'b1;
            else if (i_err_clr)
                r_err <= 1'b0;
            if (w_store) begin
                r_prev     <= w_code;
                r_prev_vld <= 1'b1;
            end
        end
    end

    assign o_position   = r_pos;
    assign o_dir        = r_dir;
    assign o_step_valid = r_step;
    assign o_hall_err   = r_err;

`ifdef HALL_PERIOD_EN
    localparam logic [PER_W-1:0] PMAX = '1;

    logic [PER_W-1:0] r_pcnt, r_period;
    logic             r_pvld, r_stall, r_armed;
    logic [PER_W-1:0] w_pcnt_inc;

    assign w_pcnt_inc = (r_pcnt == PMAX) ? PMAX : r_pcnt + {{(PER_W-1){1'b0}}, 1'b1};

    // A saturated count means the interval is unknown, so it is not reported.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pcnt   <= '0;
            r_period <= '0;
            r_pvld   <= 1'b0;
            r_stall  <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_pvld <= 1'b0;
            if (w_step) begin
                r_period <= r_pcnt;
                r_pvld   <= r_armed && (r_pcnt != PMAX);
                r_pcnt   <= {{(PER_W-1){1'b0}}, 1'b1};
                r_stall  <= 1'b0;
                r_armed  <= 1'b1;
            end else begin
                r_pcnt  <= w_pcnt_inc;
                r_stall <= (w_pcnt_inc == PMAX);
            end
        end
    end

    assign o_period       = r_period;
    assign o_period_valid = r_pvld;
    assign o_stall        = r_stall;
`else
    assign o_period       = '0;
    assign o_period_valid = 1'b0;
    assign o_stall        = 1'b0;
`endif

endmodule

// File: tb/tb_hall_pos_tracker.sv
// Table-driven bench for hall_pos_tracker: a 32-bit default instance and an
// 8-bit / 4-bit-period / DIR_INV=1 instance share the same hall stimulus.
module tb_hall_pos_tracker;

    localparam int FL = 4;
`ifdef HALL_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pos_clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [2:0]  hall = 3'b001;

    logic [31:0] m_pos;
    logic        m_dir, m_step, m_err, m_pv, m_stall;
    logic [23:0] m_per;
    logic [7:0]  a_pos;
    logic        a_dir, a_step, a_err, a_pv, a_stall;
    logic [3:0]  a_per;

    hall_pos_tracker #(.POS_W(32), .FILT_LEN(FL), .PER_W(24), .DIR_INV(0)) u_dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_hall(hall), .i_pos_clr(pos_clr),
        .i_err_clr(err_clr), .o_position(m_pos), .o_dir(m_dir), .o_step_valid(m_step),
        .o_hall_err(m_err), .o_period(m_per), .o_period_valid(m_pv), .o_stall(m_stall)
    );

    hall_pos_tracker #(.POS_W(8), .FILT_LEN(FL), .PER_W(4), .DIR_INV(1)) u_alt (
        .i_clk(clk), .i_reset_n(reset_n), .i_hall(hall), .i_pos_clr(pos_clr),
        .i_err_clr(err_clr), .o_position(a_pos), .o_dir(a_dir), .o_step_valid(a_step),
        .o_hall_err(a_err), .o_period(a_per), .o_period_valid(a_pv), .o_stall(a_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] hall;
        int         hold;
        bit         step;
        bit         dir;
        int         pos;
        bit         err;
    } vec_t;

    vec_t        vecs [18];
    vec_t        sb [$];
    logic [2:0]  seq_tab [6];
    int          cur;
    int          n_chk = 0, n_pass = 0;
    int          n_step = 0, n_pv = 0;
    logic [23:0] last_per = '0;
    int          s0;

    always @(negedge clk) begin
        if (m_step) n_step = n_step + 1;
        if (m_pv) begin
            n_pv     = n_pv + 1;
            last_per = m_per;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Drive one record; the expectation waits in the scoreboard until the
    // step edge FL+3 clocks later, then the remaining hold cycles elapse.
    task automatic run_vec(input vec_t v);
        vec_t       e;
        logic [7:0] ea;
        hall = v.hall;
        sb.push_back(v);
        repeat (FL + 3) @(posedge clk);
        #1;
        e  = sb.pop_front();
        ea = 8'(-e.pos);
        chk("step_valid", 32'(m_step), 32'(e.step));
        chk("position", m_pos, 32'(e.pos));
        chk("dir", 32'(m_dir), 32'(e.dir));
        chk("hall_err", 32'(m_err), 32'(e.err));
        chk("alt_position", 32'(a_pos), 32'(ea));
        if (e.step) chk("alt_dir", 32'(a_dir), 32'(!e.dir));
        repeat (v.hold - FL - 3) @(posedge clk);
        #1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) run_vec(vecs[i]);
    endtask

    task automatic rev_drive();
        cur  = (cur + 5) % 6;
        hall = seq_tab[cur];
    endtask

    initial begin
        seq_tab[0] = 3'b001; seq_tab[1] = 3'b011; seq_tab[2] = 3'b010;
        seq_tab[3] = 3'b110; seq_tab[4] = 3'b100; seq_tab[5] = 3'b101;
        //           hall    hold step dir pos err
        vecs[0]  = '{3'b001, 20, 1'b0, 1'b1, 0, 1'b0};
        vecs[1]  = '{3'b011, 20, 1'b1, 1'b1, 1, 1'b0};
        vecs[2]  = '{3'b010, 20, 1'b1, 1'b1, 2, 1'b0};
        vecs[3]  = '{3'b110, 20, 1'b1, 1'b1, 3, 1'b0};
        vecs[4]  = '{3'b100, 20, 1'b1, 1'b1, 4, 1'b0};
        vecs[5]  = '{3'b101, 20, 1'b1, 1'b1, 5, 1'b0};
        vecs[6]  = '{3'b001, 20, 1'b1, 1'b1, 6, 1'b0};
        vecs[7]  = '{3'b101, 20, 1'b1, 1'b0, 5, 1'b0};
        vecs[8]  = '{3'b100, 20, 1'b1, 1'b0, 4, 1'b0};
        vecs[9]  = '{3'b110, 20, 1'b1, 1'b0, 3, 1'b0};
        vecs[10] = '{3'b010, 20, 1'b1, 1'b0, 2, 1'b0};
        vecs[11] = '{3'b011, 20, 1'b1, 1'b0, 1, 1'b0};
        vecs[12] = '{3'b010, 20, 1'b1, 1'b1, 2, 1'b0};
        vecs[13] = '{3'b000, 20, 1'b0, 1'b1, 2, 1'b1};
        vecs[14] = '{3'b011, 20, 1'b1, 1'b0, 1, 1'b0};
        vecs[15] = '{3'b001, 20, 1'b1, 1'b0, 0, 1'b0};
        vecs[16] = '{3'b110, 20, 1'b0, 1'b0, 0, 1'b1};
        vecs[17] = '{3'b100, 20, 1'b1, 1'b1, 1, 1'b1};

        // reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_position", m_pos, 32'h0);
        chk("rst_dir", 32'(m_dir), 32'h1);
        chk("rst_step_valid", 32'(m_step), 32'h0);
        chk("rst_hall_err", 32'(m_err), 32'h0);
        chk("rst_period", 32'(m_per), 32'h0);
        chk("rst_period_valid", 32'(m_pv), 32'h0);
        chk("rst_stall", 32'(m_stall), 32'h0);
        reset_n = 1'b1;

        // six forward steps, 20 cycles apart
        run_range(0, 6);
        chk("fwd_step_count", 32'(n_step), 32'd6);
        chk("fwd_period_valid_count", 32'(n_pv), PER_EN ? 32'd5 : 32'd0);
        chk("fwd_period", 32'(last_per), PER_EN ? 32'd20 : 32'd0);

        // reverse steps back down to 011
        run_range(7, 11);

        // glitch shorter than the filter
        s0   = n_step;
        hall = 3'b010;
        repeat (FL - 1) @(posedge clk);
        #1;
        hall = 3'b011;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_no_step", 32'(n_step - s0), 32'd0);
        chk("glitch_position", m_pos, 32'd1);
        chk("glitch_no_err", 32'(m_err), 32'h0);

        run_range(12, 13);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr", 32'(m_err), 32'h0);
        run_range(14, 17);

        // err_clr landing on the same edge as a new 111 error
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr2", 32'(m_err), 32'h0);
        hall = 3'b111;
        repeat (FL + 2) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_set_wins", 32'(m_err), 32'h1);
        chk("err_111_position", m_pos, 32'd1);
        s0   = n_step;
        hall = 3'b100;
        repeat (12) @(posedge clk);
        #1;
        chk("err_111_no_step", 32'(n_step - s0), 32'd0);
        chk("err_sticky", 32'(m_err), 32'h1);

        // 8-bit wrap on the DIR_INV instance
        cur     = 4;
        pos_clr = 1'b1;
        @(posedge clk);
        #1;
        pos_clr = 1'b0;
        chk("pos_clr_main", m_pos, 32'h0);
        chk("pos_clr_alt", 32'(a_pos), 32'h0);
        s0 = n_step;
        for (int k = 0; k < 127; k++) begin
            rev_drive();
            repeat (8) @(posedge clk);
            #1;
        end
        chk("wrap_step_count", 32'(n_step - s0), 32'd127);
        chk("alt_pos_127", 32'(a_pos), 32'h7f);
        chk("main_pos_m127", m_pos, 32'hffffff81);
        rev_drive();
        repeat (FL + 3) @(posedge clk);
        #1;
        chk("wrap_alt_step", 32'(a_step), 32'h1);
        chk("wrap_alt_pos", 32'(a_pos), 32'h80);
        chk("wrap_main_pos", m_pos, 32'hffffff80);
        @(posedge clk);
        #1;
        rev_drive();
        repeat (FL + 2) @(posedge clk);
        #1;
        pos_clr = 1'b1;
        @(posedge clk);
        #1;
        pos_clr = 1'b0;
        chk("clr_step_main_pos", m_pos, 32'h0);
        chk("clr_step_alt_pos", 32'(a_pos), 32'h0);
        chk("clr_step_valid", 32'(m_step), 32'h1);
        chk("clr_step_dir", 32'(m_dir), 32'h0);
        chk("clr_step_alt_dir", 32'(a_dir), 32'h1);

        // 4-bit period counter saturates 14 cycles after the restart at 1
        repeat (13) @(posedge clk);
        #1;
        chk("stall_pre", 32'(a_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("stall_at_15", 32'(a_stall), 32'(PER_EN));
        chk("main_no_stall", 32'(m_stall), 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("stall_held", 32'(a_stall), 32'(PER_EN));
        rev_drive();
        repeat (FL + 3) @(posedge clk);
        #1;
        chk("stall_step", 32'(a_step), 32'h1);
        chk("stall_cleared", 32'(a_stall), 32'h0);
        chk("stall_no_pvld", 32'(a_pv), 32'h0);
        chk("main_pvld", 32'(m_pv), 32'(PER_EN));
        chk("main_period_27", 32'(m_per), PER_EN ? 32'd27 : 32'd0);

        // reset in the middle of filtering a new code
        rev_drive();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_pos", m_pos, 32'h0);
        chk("midrst_dir", 32'(m_dir), 32'h1);
        reset_n = 1'b1;
        s0 = n_step;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_first_no_step", 32'(n_step - s0), 32'd0);
        rev_drive();
        repeat (FL + 3) @(posedge clk);
        #1;
        chk("midrst_step", 32'(m_step), 32'h1);
        chk("midrst_main_pos", m_pos, 32'hffffffff);
        chk("midrst_alt_pos", 32'(a_pos), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
